// File: rtl/img_loader_pkg.sv
// Shared types and defaults for the UART image loader: loader/receiver state
// encodings, frame buffer geometry and the start-of-frame marker.
package img_loader_pkg;

    localparam int unsigned DEF_ADDR_W     = 17;
    localparam int unsigned DEF_DATA_W     = 12;
    localparam int unsigned DEF_IMG_PIXELS = 76_800;
    localparam logic [7:0]  DEF_SYNC_BYTE  = 8'hA5;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_HI,
        LD_LO
    } ld_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// UART 8N1 receiver: two-flop synchroniser, falling-edge start detection with a
// mid-bit glitch check, centre sampling, one-cycle valid / framing-error pulses.
module uart_rx
    import img_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;

    logic             r_sync1, r_sync2, r_rx_prev;
    rx_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_bit, w_bit_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic [7:0]       r_data, w_data_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_ferr, w_ferr_nxt;

    // Synchroniser resets to the idle-high line level so reset never looks like a start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        case (r_state)
            RX_IDLE: begin
                // Edge (not level) detection: a line left low after a framing error cannot retrigger
                if (r_rx_prev && !r_sync2) w_state_nxt = RX_START;
            end
            RX_START: begin
                if (r_cnt == CNT_W'(HALF - 1)) begin
                    w_state_nxt = r_sync2 ? RX_IDLE : RX_DATA;
                    w_bit_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    w_shift_nxt = {r_sync2, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) w_state_nxt = RX_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    w_state_nxt = RX_IDLE;
                    if (r_sync2) begin
                        w_valid_nxt = 1'b1;
                        w_data_nxt  = r_shift;
                    end else begin
                        w_ferr_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = RX_IDLE;
        endcase
    end

    assign data     = r_data;
    assign rx_valid = r_valid;
    assign rx_ferr  = r_ferr;

endmodule

// File: rtl/uart_image_loader.sv
// Loads an RGB444 frame received over UART into the frame buffer write port:
// sync byte, then hi/lo byte pairs packed into sequential pixel writes.
module uart_image_loader
    import img_loader_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 100_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter int unsigned IMG_PIXELS  = DEF_IMG_PIXELS,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter logic [7:0]  SYNC_BYTE   = DEF_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYC = CLK_FREQ / 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned GAP_W        = $clog2(TIMEOUT_CYC + 1);

    logic [7:0] w_rx_data;
    logic       w_rx_valid, w_rx_ferr;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .data     (w_rx_data),
        .rx_valid (w_rx_valid),
        .rx_ferr  (w_rx_ferr)
    );

    ld_state_t         r_state, w_state_nxt;
    logic [3:0]        r_hi, w_hi_nxt;
    logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
    logic [GAP_W-1:0]  r_gap, w_gap_nxt;
    logic              r_we, w_we_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_din, w_din_nxt;
    logic              r_busy, r_done, w_done_nxt, r_err, w_err_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LD_IDLE;
            r_hi    <= '0;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hi    <= w_hi_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gap   <= w_gap_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_din   <= w_din_nxt;
            r_busy  <= (w_state_nxt != LD_IDLE);
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Byte reception takes priority over a framing error or a coincident timeout
    always_comb begin
        w_state_nxt = r_state;
        w_hi_nxt    = r_hi;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = '0;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = r_addr;
        w_din_nxt   = r_din;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            LD_IDLE: begin
                if (w_rx_valid && (w_rx_data == SYNC_BYTE)) begin
                    w_state_nxt = LD_HI;
                    w_cnt_nxt   = '0;
                end
            end
            LD_HI, LD_LO: begin
                w_gap_nxt = r_gap + GAP_W'(1);
                if (w_rx_valid) begin
                    w_gap_nxt = '0;
                    if (r_state == LD_HI) begin
                        w_hi_nxt    = w_rx_data[3:0];
                        w_state_nxt = LD_LO;
                    end else begin
                        w_we_nxt   = 1'b1;
                        w_addr_nxt = r_cnt;
                        w_din_nxt  = DATA_W'({r_hi, w_rx_data});
                        if (r_cnt == ADDR_W'(IMG_PIXELS - 1)) begin
                            w_done_nxt  = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = LD_IDLE;
                        end else begin
                            w_cnt_nxt   = r_cnt + ADDR_W'(1);
                            w_state_nxt = LD_HI;
                        end
                    end
                end else if (w_rx_ferr || (r_gap == GAP_W'(TIMEOUT_CYC - 1))) begin
                    w_gap_nxt   = '0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = LD_IDLE;
                end
            end
            default: w_state_nxt = LD_IDLE;
        endcase
    end

    assign bram_we    = r_we;
    assign bram_addr  = r_addr;
    assign bram_din   = r_din;
    assign busy       = r_busy;
    assign frame_done = r_done;
    assign frame_err  = r_err;

endmodule

// File: tb/tb_uart_image_loader.sv
// Directed bench for uart_image_loader at 10 clk/bit, 4-pixel frames, 300-clk timeout.
module tb_uart_image_loader;

    localparam int unsigned ADDR_W = 17;
    localparam int unsigned DATA_W = 12;
    localparam int unsigned CPB    = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx  = 1'b1;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic              busy, frame_done, frame_err;

    always #5 clk = ~clk;

    uart_image_loader #(
        .CLK_FREQ    (1_000_000),
        .BAUD        (100_000),
        .IMG_PIXELS  (4),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (300)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt, done_cnt, stray_done;
    int wr_addr[$];
    int wr_data[$];
    int wr_done[$];

    // Write-port log, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (bram_we) begin
                wr_addr.push_back(int'(bram_addr));
                wr_data.push_back(int'(bram_din));
                wr_done.push_back(int'(frame_done));
            end
            if (frame_err) err_cnt++;
            if (frame_done) done_cnt++;
            if (frame_done && !bram_we) stray_done++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = stop;
        idle(CPB);
        rx = 1'b1;
        idle(3);
    endtask

    task automatic send(input logic [7:0] b);
        send_byte(b, 1'b1);
    endtask

    task automatic clear_log;
        wr_addr.delete();
        wr_data.delete();
        wr_done.delete();
        err_cnt    = 0;
        done_cnt   = 0;
        stray_done = 0;
    endtask

    task automatic send_frame1;
        send(8'hA5);
        send(8'h0F); send(8'h00);
        send(8'h00); send(8'hF0);
        send(8'h00); send(8'h0F);
        send(8'h0C); send(8'h34);
        idle(5);
    endtask

    task automatic check_frame(input string tag, input int exp_px [4]);
        check($sformatf("%s_nwr", tag), 32'(wr_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wr_addr.size()) begin
                check($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[i]), 32'(i));
                check($sformatf("%s_din%0d", tag, i), 32'(wr_data[i]), 32'(exp_px[i]));
                check($sformatf("%s_done%0d", tag, i), 32'(wr_done[i]), (i == 3) ? 32'd1 : 32'd0);
            end
        end
        check($sformatf("%s_ndone", tag), 32'(done_cnt), 32'd1);
        check($sformatf("%s_stray", tag), 32'(stray_done), 32'd0);
        check($sformatf("%s_err", tag), 32'(err_cnt), 32'd0);
        check($sformatf("%s_busy", tag), 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_log();
        idle(3);
        check("rst_we", 32'(bram_we), 32'd0);
        check("rst_addr", 32'(bram_addr), 32'd0);
        check("rst_din", 32'(bram_din), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        idle(5);

        // Full frame
        clear_log();
        send(8'hA5);
        check("t1_busy_hi", 32'(busy), 32'd1);
        send(8'h0F); send(8'h00);
        send(8'h00); send(8'hF0);
        send(8'h00); send(8'h0F);
        send(8'h0C); send(8'h34);
        idle(5);
        check_frame("t1", '{32'hF00, 32'h0F0, 32'h00F, 32'hC34});

        // Noise before sync
        clear_log();
        send(8'h12); send(8'h34);
        check("t2_prewr", 32'(wr_addr.size()), 32'd0);
        check("t2_prebusy", 32'(busy), 32'd0);
        send_frame1();
        check_frame("t2", '{32'hF00, 32'h0F0, 32'h00F, 32'hC34});

        // Upper nibble ignored, sync byte as data
        clear_log();
        send(8'hA5); send(8'hFA); send(8'hA5);
        check("t3_busy", 32'(busy), 32'd1);
        send(8'h00); send(8'h11);
        send(8'h00); send(8'h22);
        send(8'h0F); send(8'hFF);
        idle(5);
        check_frame("t3", '{32'hAA5, 32'h011, 32'h022, 32'hFFF});

        // Timeout inside a frame
        clear_log();
        send(8'hA5); send(8'h01); send(8'h23); send(8'h04);
        idle(250);
        check("t4_early_err", 32'(err_cnt), 32'd0);
        check("t4_early_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 100 && err_cnt == 0; k++) idle(1);
        idle(2);
        check("t4_err", 32'(err_cnt), 32'd1);
        check("t4_nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() > 0) begin
            check("t4_addr0", 32'(wr_addr[0]), 32'd0);
            check("t4_din0", 32'(wr_data[0]), 32'h123);
        end
        check("t4_busy", 32'(busy), 32'd0);
        clear_log();
        send(8'hA5);
        send(8'h05); send(8'h67);
        send(8'h00); send(8'h01);
        send(8'h00); send(8'h02);
        send(8'h00); send(8'h03);
        idle(5);
        check_frame("t4b", '{32'h567, 32'h001, 32'h002, 32'h003});

        // Framing error inside a frame
        clear_log();
        send(8'hA5); send(8'h01);
        send_byte(8'h55, 1'b0);
        idle(20);
        check("t5_err", 32'(err_cnt), 32'd1);
        check("t5_nwr", 32'(wr_addr.size()), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);

        // Short start glitch must not be taken as a byte
        clear_log();
        send(8'hA5);
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(20);
        send(8'h0A); send(8'hBC);
        send(8'h01); send(8'h02);
        send(8'h03); send(8'h04);
        send(8'h05); send(8'h06);
        idle(5);
        check_frame("t5g", '{32'hABC, 32'h102, 32'h304, 32'h506});

        // Asynchronous reset mid-frame
        clear_log();
        send(8'hA5); send(8'h01);
        check("t6_busy_pre", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_we", 32'(bram_we), 32'd0);
        check("t6_addr", 32'(bram_addr), 32'd0);
        check("t6_din", 32'(bram_din), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(frame_done), 32'd0);
        check("t6_err", 32'(frame_err), 32'd0);
        idle(3);
        rst = 1'b0;
        idle(5);
        clear_log();
        send(8'hA5);
        send(8'h01); send(8'h11);
        send(8'h02); send(8'h22);
        send(8'h03); send(8'h33);
        send(8'h04); send(8'h44);
        idle(5);
        check_frame("t6", '{32'h111, 32'h222, 32'h333, 32'h444});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
